// File: rtl/load_seq_ext_ctrl.sv
// MEM-stage sub-word load sequencer: issues a word read, waits for a variable-latency ack,
// then extracts and sign/zero-extends the addressed byte or halfword.
module load_seq_ext_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic        flush,
   output logic        busy,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [1:0]  err_code
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LB  = 3'b001;
   localparam logic [2:0] OP_LBU = 3'b010;
   localparam logic [2:0] OP_LH  = 3'b011;
   localparam logic [2:0] OP_LHU = 3'b100;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ALIGN   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_OP      = 2'b11;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  count;
   logic [2:0]  op_q;
   logic [1:0]  off_q;
   logic        op_reserved;
   logic        misaligned;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] extracted;

   always_comb begin
      op_reserved = (req_op > OP_LHU);
      misaligned  = 1'b0;
      case (req_op)
         OP_LW:         misaligned = (req_addr[1:0] != 2'b00);
         OP_LH, OP_LHU: misaligned = req_addr[0];
         default:       misaligned = 1'b0;
      endcase
   end

   // Lane select uses the offset latched at accept time, not the live request address.
   always_comb begin
      byte_sel  = 8'h00;
      case (off_q)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      extracted = 32'h0;
      case (op_q)
         OP_LW:   extracted = mem_rdata;
         OP_LB:   extracted = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  extracted = {24'h0, byte_sel};
         OP_LH:   extracted = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  extracted = {16'h0, half_sel};
         default: extracted = 32'h0;
      endcase
   end

   assign busy       = (state == IDLE && req_valid && !flush) || (state == WAIT);
   assign resp_valid = (state == RESP) && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_rd_en <= 1'b0;
         mem_addr  <= 32'h0;
         resp_data <= 32'h0;
         err_code  <= ERR_NONE;
         count     <= 8'h0;
         op_q      <= 3'b000;
         off_q     <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && !flush) begin
                  if (op_reserved || misaligned) begin
                     state     <= RESP;
                     resp_data <= 32'h0;
                     err_code  <= op_reserved ? ERR_OP : ERR_ALIGN;
                  end else begin
                     op_q      <= req_op;
                     off_q     <= req_addr[1:0];
                     mem_rd_en <= 1'b1;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     count     <= 8'h0;
                     state     <= WAIT;
                  end
               end
            end
            WAIT: begin
               // Flush wins over a same-cycle ack; dropping rd_en cancels the read.
               if (flush) begin
                  state     <= IDLE;
                  mem_rd_en <= 1'b0;
               end else if (mem_ack) begin
                  mem_rd_en <= 1'b0;
                  resp_data <= extracted;
                  err_code  <= ERR_NONE;
                  state     <= RESP;
               end else if (count == TIMEOUT_LAST) begin
                  mem_rd_en <= 1'b0;
                  resp_data <= 32'h0;
                  err_code  <= ERR_TIMEOUT;
                  state     <= RESP;
               end else begin
                  count <= count + 8'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
